// File: rtl/efpga_cfg_pkg.sv
// Shared constants and helpers for the configuration-side frame strobe sequencer.
// State codes are plain localparams so they stay compatible with older tools.
package efpga_cfg_pkg;

   localparam int NUM_COLUMNS_DEF = 10;
   localparam int MAX_FRAMES_DEF  = 20;
   localparam int COL_W           = $clog2(NUM_COLUMNS_DEF);
   localparam int FRM_W           = $clog2(MAX_FRAMES_DEF);
   localparam int ST_W            = 3;

   typedef logic [ST_W-1:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SETUP  = 3'd1;
   localparam state_t ST_STROBE = 3'd2;
   localparam state_t ST_HOLD   = 3'd3;
   localparam state_t ST_ERR    = 3'd4;

   // Column c, frame f lives at bit c*frames_per_col+f of the flat strobe bus.
   function automatic int strobe_bit(input int col, input int frame, input int frames_per_col);
      return col * frames_per_col + frame;
   endfunction

   // Width of one down-counter able to hold the longest phase length minus one.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder: the strobe bit for (col, frame) comes straight off a flop,
// so the column frame registers never see decode glitches.
module frame_strobe_decoder
   import efpga_cfg_pkg::*;
#(
   parameter int NUM_COLUMNS     = NUM_COLUMNS_DEF,
   parameter int MaxFramesPerCol = MAX_FRAMES_DEF,
   parameter int COL_BITS        = $clog2(NUM_COLUMNS),
   parameter int FRM_BITS        = $clog2(MaxFramesPerCol)
) (
   input  logic                                   CLK,
   input  logic                                   resetn,
   input  logic                                   en,
   input  logic [COL_BITS-1:0]                    col,
   input  logic [FRM_BITS-1:0]                    frame,
   output logic [NUM_COLUMNS*MaxFramesPerCol-1:0] strobe
);

   localparam int N = NUM_COLUMNS * MaxFramesPerCol;

   logic [N-1:0] strobe_nxt;
   int           sel;

   always_comb begin
      sel        = strobe_bit(int'(col), int'(frame), MaxFramesPerCol);
      strobe_nxt = '0;
      for (int i = 0; i < N; i++) begin
         strobe_nxt[i] = en && (sel == i);
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         strobe <= '0;
      end else begin
         strobe <= strobe_nxt;
      end
   end

endmodule

// File: rtl/frame_strobe_seq.sv
// Frame-write sequencer: accepts one request at a time, presents FrameData and fires a single
// registered strobe with setup/strobe/hold timing; sweep mode zero-fills every frame of a column.
module frame_strobe_seq
   import efpga_cfg_pkg::*;
#(
   parameter int NUM_COLUMNS     = NUM_COLUMNS_DEF,
   parameter int MaxFramesPerCol = MAX_FRAMES_DEF,
   parameter int FrameBitsPerRow = 32,
   parameter int SETUP_CYCLES    = 1,
   parameter int STROBE_CYCLES   = 2,
   parameter int HOLD_CYCLES     = 1
) (
   input  logic                                   CLK,
   input  logic                                   resetn,
   // Handshake: a request transfers on any rising CLK where req_valid && req_ready;
   // req_ready is high only in IDLE and inputs are ignored at all other times.
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_sweep,
   input  logic [$clog2(NUM_COLUMNS)-1:0]         req_col,
   input  logic [$clog2(MaxFramesPerCol)-1:0]     req_frame,
   input  logic [FrameBitsPerRow-1:0]             req_data,
   output logic [FrameBitsPerRow-1:0]             FrameData,
   output logic [NUM_COLUMNS*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err,
   output logic [ST_W-1:0]                        state_dbg
);

   localparam int CB = $clog2(NUM_COLUMNS);
   localparam int FB = $clog2(MaxFramesPerCol);
   localparam int CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CB-1:0] col_q;
   logic [FB-1:0] frame_q;
   logic          sweep_q;
   logic          accept;
   logic          req_bad;
   logic          phase_end;
   logic          last_frame;
   logic          strobe_en;

   assign accept     = req_valid && req_ready;
   assign req_bad    = (int'(req_col) >= NUM_COLUMNS) ||
                       (!req_sweep && (int'(req_frame) >= MaxFramesPerCol));
   assign phase_end  = (cnt == '0);
   assign last_frame = !sweep_q || (int'(frame_q) == MaxFramesPerCol - 1);

   assign req_ready  = (state == ST_IDLE);
   assign busy       = ~req_ready;
   assign done       = (state == ST_HOLD) && phase_end && last_frame;
   assign err        = (state == ST_ERR);
   assign state_dbg  = state;

   // The decoder flop adds a cycle, so enable it one cycle ahead of the STROBE window.
   assign strobe_en  = ((state == ST_SETUP) && phase_end) ||
                       ((state == ST_STROBE) && !phase_end);

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         col_q     <= '0;
         frame_q   <= '0;
         sweep_q   <= 1'b0;
         FrameData <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  col_q   <= req_col;
                  sweep_q <= req_sweep;
                  frame_q <= req_sweep ? '0 : req_frame;
                  if (req_bad) begin
                     state <= ST_ERR;
                  end else begin
                     state     <= ST_SETUP;
                     cnt       <= CW'(SETUP_CYCLES - 1);
                     FrameData <= req_sweep ? '0 : req_data;
                  end
               end
            end
            ST_SETUP: begin
               if (phase_end) begin
                  state <= ST_STROBE;
                  cnt   <= CW'(STROBE_CYCLES - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STROBE: begin
               if (phase_end) begin
                  state <= ST_HOLD;
                  cnt   <= CW'(HOLD_CYCLES - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (!phase_end) begin
                  cnt <= cnt - 1'b1;
               end else if (last_frame) begin
                  state <= ST_IDLE;
               end else begin
                  frame_q <= frame_q + 1'b1;
                  state   <= ST_SETUP;
                  cnt     <= CW'(SETUP_CYCLES - 1);
               end
            end
            ST_ERR:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   frame_strobe_decoder #(
      .NUM_COLUMNS     (NUM_COLUMNS),
      .MaxFramesPerCol (MaxFramesPerCol),
      .COL_BITS        (CB),
      .FRM_BITS        (FB)
   ) u_decoder (
      .CLK    (CLK),
      .resetn (resetn),
      .en     (strobe_en),
      .col    (col_q),
      .frame  (frame_q),
      .strobe (FrameStrobe)
   );

   a_strobe_onehot: assert property (@(posedge CLK) disable iff (!resetn) $onehot0(FrameStrobe));

endmodule

// File: tb/tb_frame_strobe_seq.sv
// Randomized bench for frame_strobe_seq: a transaction-level model predicts every strobe,
// done and err event into a queue; a negedge monitor pops and compares as the DUT produces them.
module tb_frame_strobe_seq;
   localparam int NC = 10;
   localparam int MF = 20;
   localparam int S  = 1;
   localparam int T  = 2;
   localparam int H  = 1;
   localparam int NB = NC * MF;
   localparam int EW = 58;

   // clock / reset
   logic CLK = 1'b0;
   logic resetn = 1'b0;
   always #5 CLK = ~CLK;
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   logic          req_valid = 1'b0;
   logic          req_sweep = 1'b0;
   logic [3:0]    req_col   = '0;
   logic [4:0]    req_frame = '0;
   logic [31:0]   req_data  = '0;
   logic          req_ready, busy, done, err;
   logic [31:0]   FrameData;
   logic [NB-1:0] FrameStrobe;
   logic [2:0]    state_dbg;

   logic          b_valid = 1'b0;
   logic [3:0]    b_col   = '0;
   logic [4:0]    b_frame = '0;
   logic [31:0]   b_data  = '0;
   logic          b_ready, b_busy, b_done, b_err;
   logic [31:0]   b_fd;
   logic [NB-1:0] b_fs;
   logic [2:0]    b_state;

   frame_strobe_seq dut (
      .CLK(CLK), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
      .req_sweep(req_sweep), .req_col(req_col), .req_frame(req_frame), .req_data(req_data),
      .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done),
      .err(err), .state_dbg(state_dbg)
   );

   frame_strobe_seq #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) dut_b (
      .CLK(CLK), .resetn(resetn), .req_valid(b_valid), .req_ready(b_ready),
      .req_sweep(1'b0), .req_col(b_col), .req_frame(b_frame), .req_data(b_data),
      .FrameData(b_fd), .FrameStrobe(b_fs), .busy(b_busy), .done(b_done),
      .err(b_err), .state_dbg(b_state)
   );

   // scoreboard state
   logic [EW-1:0] exp_q[$];
   bit            busy_map [0:65535];
   int            free_cyc = 0;
   logic [31:0]   fd_model = '0;
   bit            mon_en = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;

   function automatic logic [EW-1:0] mk_ev(input int kind, input int c, input int b, input logic [31:0] d);
      return {2'(kind), 16'(c), 8'(b), d};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic got(input logic [EW-1:0] e);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event @cyc %0d: got kind=%0d cyc=%0d bit=%0d data=%0h expected none",
                  cyc, e[57:56], e[55:40], e[39:32], e[31:0]);
      end else begin
         chk("event(kind,cyc,bit,data)", 256'(e), 256'(exp_q.pop_front()));
      end
   endtask

   // reference model: per-request event timeline from the phase lengths
   task automatic model(input int a, input bit sw, input int col, input int frame, input logic [31:0] d);
      int p, nfr, f0, fin;
      p = S + T + H;
      if (col >= NC || (!sw && frame >= MF)) begin
         exp_q.push_back(mk_ev(3, a + 1, 0, fd_model));
         fin = a + 1;
      end else begin
         nfr      = sw ? MF : 1;
         f0       = sw ? 0 : frame;
         fd_model = sw ? 32'h0 : d;
         for (int k = 0; k < nfr; k++)
            for (int t = 1; t <= T; t++)
               exp_q.push_back(mk_ev(1, a + k * p + S + t, col * MF + f0 + k, fd_model));
         fin = a + nfr * p;
         exp_q.push_back(mk_ev(2, fin, 0, fd_model));
      end
      for (int i = a + 1; i <= fin; i++) busy_map[i] = 1'b1;
      free_cyc = fin + 1;
   endtask

   // driver: valid stays high across back-to-back requests when gap is 0
   task automatic issue(input bit sw, input int col, input int frame, input logic [31:0] d, input int gap);
      int a;
      if (gap > 0) begin
         req_valid = 1'b0;
         repeat (gap) begin @(posedge CLK); #1; end
      end
      req_sweep = sw;
      req_col   = 4'(col);
      req_frame = 5'(frame);
      req_data  = d;
      req_valid = 1'b1;
      a = (cyc > free_cyc) ? cyc : free_cyc;
      model(a, sw, col, frame, d);
      while (cyc < a + 1) begin @(posedge CLK); #1; end
   endtask

   task automatic drain();
      req_valid = 1'b0;
      while (cyc < free_cyc + 2) begin @(posedge CLK); #1; end
      chk("drain_queue_empty", 256'(exp_q.size()), 256'(0));
   endtask

   // monitor
   always @(negedge CLK) begin
      if (mon_en) begin
         chk("req_ready", 256'({req_ready, busy}), 256'({!busy_map[cyc], busy_map[cyc]}));
         if (FrameStrobe !== '0) begin
            int idx;
            idx = 0;
            chk("strobe_onehot", 256'($onehot(FrameStrobe)), 256'(1));
            for (int i = 0; i < NB; i++) if (FrameStrobe[i]) idx = i;
            got(mk_ev(1, cyc, idx, FrameData));
         end
         if (done) got(mk_ev(2, cyc, 0, FrameData));
         if (err)  got(mk_ev(3, cyc, 0, FrameData));
      end
   end

   initial begin
      #400000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : main
      int a;
      logic [NB-1:0] exp_v;

      repeat (3) @(posedge CLK);
      #1;
      chk("reset_ready", 256'(req_ready), 256'(1));
      chk("reset_strobe", 256'(FrameStrobe), 256'(0));
      chk("reset_data", 256'(FrameData), 256'(0));
      chk("reset_done_err", 256'({done, err}), 256'(0));
      resetn   = 1'b1;
      free_cyc = cyc;
      mon_en   = 1'b1;

      issue(0, 3, 5, 32'hA5A5_0F0F, 0);
      issue(1, 9, 7, 32'hFFFF_FFFF, 2);
      issue(0, 10, 0, 32'h1111_2222, 1);
      issue(0, 2, 20, 32'h3333_4444, 1);
      issue(0, 0, 0, 32'h0000_0001, 1);
      issue(0, 9, 19, 32'h8000_0000, 0);
      issue(0, 5, 10, 32'h5555_AAAA, 0);
      for (int i = 0; i < 40; i++)
         issue($urandom_range(0, 7) == 0, $urandom_range(0, 11), $urandom_range(0, 21),
               $urandom, $urandom_range(0, 2));
      drain();

      // async reset in the middle of a strobe
      mon_en    = 1'b0;
      req_sweep = 1'b0;
      req_col   = 4'd4;
      req_frame = 5'd11;
      req_data  = 32'hDEAD_BEEF;
      req_valid = 1'b1;
      a = cyc;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      while (cyc < a + 3) begin @(posedge CLK); #1; end
      exp_v = '0;
      exp_v[4 * MF + 11] = 1'b1;
      chk("pre_reset_strobe", 256'(FrameStrobe), 256'(exp_v));
      #2 resetn = 1'b0;
      #1;
      chk("async_strobe_clear", 256'(FrameStrobe), 256'(0));
      chk("async_ready", 256'(req_ready), 256'(1));
      chk("async_data_clear", 256'(FrameData), 256'(0));
      @(posedge CLK); #1;
      resetn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         chk("post_reset_quiet", 256'({FrameStrobe, done, err, req_ready}), 256'(1));
      end
      @(posedge CLK); #1;
      fd_model = '0;
      free_cyc = cyc;
      mon_en   = 1'b1;
      issue(0, 1, 1, 32'h0BAD_F00D, 0);
      drain();

      // alternate timing instance: setup 3, strobe 1, hold 2
      b_col   = 4'd2;
      b_frame = 5'd7;
      b_data  = 32'h1234_5678;
      b_valid = 1'b1;
      a = cyc;
      @(posedge CLK); #1;
      b_valid = 1'b0;
      exp_v = '0;
      exp_v[2 * MF + 7] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge CLK);
         chk("alt_strobe", 256'(b_fs), (cyc - a == 4) ? 256'(exp_v) : 256'(0));
         chk("alt_done", 256'(b_done), 256'(cyc - a == 6));
         chk("alt_ready", 256'(b_ready), 256'(cyc - a >= 7));
         chk("alt_data", 256'(b_fd), 256'(32'h1234_5678));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_strobe_seq.md
Name: frame_strobe_seq

Overview:
Configuration-side controller that drives the per-column FrameStrobe buses of the fabric. The column chain runs through the terminal tiles, which forward FrameStrobe and UserCLK unchanged. The block accepts frame-write requests over a valid/ready handshake, presents FrameData, and fires exactly one one-hot strobe with programmable setup, strobe-width and hold timing. A sweep mode zero-fills every frame of one column; it is used for fabric clear before partial reconfiguration.

Parameters:
NUM_COLUMNS, 10, number of fabric columns driven
MaxFramesPerCol, 20, strobe lines per column
FrameBitsPerRow, 32, FrameData width
SETUP_CYCLES, 1, data-valid cycles before strobe; legal range >=1
STROBE_CYCLES, 2, strobe high time in cycles; legal range >=1
HOLD_CYCLES, 1, data-hold cycles after strobe; legal range >=1

Ports:
CLK  in  1  configuration clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_sweep  in  1  1 = zero-fill all frames of req_col, ignore req_frame/req_data
req_col  in  clog2(NUM_COLUMNS)  target column
req_frame  in  clog2(MaxFramesPerCol)  target frame within column
req_data  in  FrameBitsPerRow  frame contents
FrameData  out  FrameBitsPerRow  data to column frame registers
FrameStrobe  out  NUM_COLUMNS*MaxFramesPerCol  column c, frame f at bit c*MaxFramesPerCol+f
busy  out  1  equals ~req_ready
done  out  1  one-cycle pulse, operation complete
err  out  1  one-cycle pulse, out-of-range request

Behaviour:
- Reset (async, any state): state IDLE; req_ready=1; FrameStrobe=0; FrameData=0; done=0; err=0. Strobe must drop in the same instant resetn falls. An aborted write leaves no partial strobe after reset.
- States: IDLE, SETUP, STROBE, HOLD, ERR.
- IDLE: req_ready=1. Accept occurs when req_valid&&req_ready. Latch col, frame, data and sweep. A sweep request forces frame=0 and data=0.
- Range check at accept: col>=NUM_COLUMNS, or (!sweep && frame>=MaxFramesPerCol) -> go to ERR. ERR lasts 1 cycle with err=1 and no strobe or data change, then returns to IDLE.
- Otherwise -> SETUP. FrameData takes the latched data from the cycle after accept. FrameData holds its value until the next accept and is not cleared at done.
- SETUP lasts SETUP_CYCLES cycles, then -> STROBE.
- STROBE lasts STROBE_CYCLES cycles. Exactly one FrameStrobe bit is high, and that bit is registered (glitch-free).
- HOLD lasts HOLD_CYCLES cycles with strobe 0.
- End of HOLD, non-sweep or last sweep frame: done=1 in the final HOLD cycle, then IDLE.
- End of HOLD, sweep not finished: increment frame, -> SETUP. FrameData stays 0.
- Sweep completes after MaxFramesPerCol strobes with frame wrap at MaxFramesPerCol-1. The frame counter never exceeds MaxFramesPerCol-1.
- Latency with defaults: accept at cycle 0; SETUP at 1; strobe high at 2–3; HOLD plus done at 4; req_ready=1 at 5. Total per frame = SETUP+STROBE+HOLD.
- Back-to-back: a request held valid during the done cycle is not accepted until the following IDLE cycle.
- Requests never overlap. Inputs are ignored while busy. The phase counter is a single down-counter sized for the maximum parameter.
- FrameStrobe is never multi-hot. Assertion: $onehot0(FrameStrobe).

Decomposition:
- Package efpga_cfg_pkg: state enum; COL_W/FRM_W/CNT_W localparams via clog2; the strobe-bit index function.
- Sub-module frame_strobe_decoder: registered one-hot decoder. Inputs are enable, col and frame; output is the FrameStrobe vector. The FSM and counters stay in frame_strobe_seq.

Test Plan:
1. Reset, then req col=3, frame=5, data=0xA5A5_0F0F -> FrameData=0xA5A5_0F0F from cycle 1; FrameStrobe bit 65 high at cycles 2–3 only; done at cycle 4; req_ready at cycle 5.
2. Sweep col=9, data=0xFFFF_FFFF -> bits 180..199 each strobe once in ascending order; FrameData=0 throughout; 80 cycles; a single done pulse at the end.
3. req col=10 (out of range) -> err pulse at cycle 1; no strobe; FrameData unchanged; req_ready at cycle 2. Same result for frame=20 with sweep=0.
4. resetn low during cycle 2 of a strobe -> FrameStrobe=0 asynchronously; no done; req_ready=1 after release.
5. req_valid held high continuously with 3 queued requests -> each accept is spaced 5 cycles apart; strobes never overlap; the one-hot assertion never fires.
6. Params SETUP=3, STROBE=1, HOLD=2 -> strobe at cycle 4 only; done at cycle 6.
